// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage sequencer for conditional branches (bgez/beq/bne/blez/bgtz).
// Detects operands still in flight, stalls the front end 0/1/2 cycles, picks comparator forwarding
// sources, and turns branch_taken into PC-redirect + IF/ID flush in the resolving cycle.
// Ports: clk/reset (async, active-high); id_* = branch in ID; ex_*/mem_*/wb_* = producer stages;
//        branch_taken = comparator result; fwd_a_sel/fwd_b_sel, stall, pc_branch_sel, flush_ifid,
//        branch_count/taken_count (live only when BRANCH_STATS_EN is defined, otherwise constant 0).
// Latency: all control outputs combinational from state + inputs; only the FSM (and counters) are flops.
module branch_hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  id_opcode,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_regwrite,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rd,
   input  logic        mem_regwrite,
   input  logic        mem_memread,
   input  logic [4:0]  mem_rd,
   input  logic        wb_regwrite,
   input  logic [4:0]  wb_rd,
   input  logic        branch_taken,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        stall,
   output logic        pc_branch_sel,
   output logic        flush_ifid,
   output logic [31:0] branch_count,
   output logic [31:0] taken_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] STALL   = 2'd1;
   localparam logic [1:0] RESOLVE = 2'd2;

   logic [1:0] state_q, state_d;
   logic       is_branch, uses_rt;
   logic       ex_match, mem_match;
   logic [1:0] need;
   logic       stall_c, resolve_c;

   // Forward source for one comparator operand; MEM ALU result wins over WB data.
   function automatic logic [1:0] fwd_src(input logic [4:0] r,
                                          input logic       m_wr,
                                          input logic       m_rd_mem,
                                          input logic [4:0] m_rd,
                                          input logic       w_wr,
                                          input logic [4:0] w_rd);
      logic [1:0] sel;
      sel = 2'd0;
      if (r != 5'd0) begin
         if (m_wr && !m_rd_mem && (m_rd == r)) sel = 2'd1;
         else if (w_wr && (w_rd == r))         sel = 2'd2;
      end
      return sel;
   endfunction

   always_comb begin
      is_branch = 1'b0;
      uses_rt   = 1'b0;
      case (id_opcode)
         6'h01, 6'h06, 6'h07: is_branch = 1'b1;
         6'h04, 6'h05: begin
            is_branch = 1'b1;
            uses_rt   = 1'b1;
         end
         default: ;
      endcase
   end

   assign ex_match  = ex_regwrite && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (uses_rt && (ex_rd == id_rt)));
   assign mem_match = mem_regwrite && (mem_rd != 5'd0) &&
                      ((mem_rd == id_rs) || (uses_rt && (mem_rd == id_rt)));

   // A load in EX needs two bubbles; an ALU op in EX or a load in MEM needs one.
   always_comb begin
      need = 2'd0;
      if (ex_match && ex_memread)                    need = 2'd2;
      else if (ex_match || (mem_match && mem_memread)) need = 2'd1;
   end

   always_comb begin
      state_d   = state_q;
      stall_c   = 1'b0;
      resolve_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_branch) begin
               if (need == 2'd0) begin
                  resolve_c = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  state_d = (need == 2'd2) ? STALL : RESOLVE;
               end
            end
         end
         STALL: begin
            stall_c = 1'b1;
            state_d = RESOLVE;
         end
         RESOLVE: begin
            // Operands are known to be forwardable now; hazards are not re-checked.
            resolve_c = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Reset gates every output so stall drops the moment reset rises.
   assign stall         = !reset && stall_c;
   assign pc_branch_sel = !reset && resolve_c && branch_taken;
   assign flush_ifid    = !reset && resolve_c && branch_taken;

   assign fwd_a_sel = (reset || !is_branch) ? 2'd0 :
                      fwd_src(id_rs, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
   assign fwd_b_sel = (reset || !is_branch || !uses_rt) ? 2'd0 :
                      fwd_src(id_rt, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] taken_count_q, taken_count_d;

   always_comb begin
      branch_count_d = branch_count_q;
      taken_count_d  = taken_count_q;
      if (resolve_c) begin
         branch_count_d = branch_count_q + 32'd1;
         if (branch_taken) taken_count_d = taken_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count_q <= 32'd0;
         taken_count_q  <= 32'd0;
      end else begin
         branch_count_q <= branch_count_d;
         taken_count_q  <= taken_count_d;
      end
   end

   assign branch_count = branch_count_q;
   assign taken_count  = taken_count_q;
`else
   assign branch_count = 32'd0;
   assign taken_count  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench for branch_hazard_ctrl: directed scenarios plus a randomized run against a
// cycle-countdown reference model of the branch sequencing rules.
module tb_branch_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  id_opcode = '0;
   logic [4:0]  id_rs = '0, id_rt = '0;
   logic        ex_regwrite = 1'b0, ex_memread = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic        mem_regwrite = 1'b0, mem_memread = 1'b0;
   logic [4:0]  mem_rd = '0;
   logic        wb_regwrite = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic        branch_taken = 1'b0;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        stall, pc_branch_sel, flush_ifid;
   logic [31:0] branch_count, taken_count;

   int errors = 0;
   int checks = 0;

`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   branch_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .branch_taken(branch_taken),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall(stall), .pc_branch_sel(pc_branch_sel), .flush_ifid(flush_ifid),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   // {stall, pc_branch_sel, flush_ifid, fwd_a_sel, fwd_b_sel}
   function automatic logic [6:0] outs();
      return {stall, pc_branch_sel, flush_ifid, fwd_a_sel, fwd_b_sel};
   endfunction

   task automatic clear_inputs();
      id_opcode = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
      ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
      mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
      wb_regwrite = 1'b0; wb_rd = 5'd0; branch_taken = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      id_opcode = 6'h04; id_rs = 5'd3; id_rt = 5'd4; branch_taken = 1'b1;
      ex_regwrite = 1'b1; ex_rd = 5'd3; mem_regwrite = 1'b1; mem_rd = 5'd4;
      @(negedge clk); #1;
      checks++;
      if (outs() !== 7'd0) begin
         errors++; $display("FAIL reset_outs: got %b expected %b", outs(), 7'd0);
      end
      checks++;
      if (branch_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", branch_count, taken_count);
      end
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
   endtask

   task automatic test_no_hazard();
      @(negedge clk);
      id_opcode = 6'h04; id_rs = 5'd3; id_rt = 5'd4; branch_taken = 1'b1;
      #1; checks++;
      if (outs() !== 7'b011_00_00) begin
         errors++; $display("FAIL beq_taken: got %b expected %b", outs(), 7'b011_00_00);
      end
      @(negedge clk);
      branch_taken = 1'b0;
      #1; checks++;
      if (outs() !== 7'b000_00_00) begin
         errors++; $display("FAIL beq_not_taken: got %b expected %b", outs(), 7'b000_00_00);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_ex_alu();
      @(negedge clk);
      id_opcode = 6'h05; id_rs = 5'd5; id_rt = 5'd6;
      ex_regwrite = 1'b1; ex_rd = 5'd5;
      #1; checks++;
      if (outs() !== 7'b100_00_00) begin
         errors++; $display("FAIL bne_ex_stall: got %b expected %b", outs(), 7'b100_00_00);
      end
      @(negedge clk);
      ex_regwrite = 1'b0; ex_rd = 5'd0;
      mem_regwrite = 1'b1; mem_rd = 5'd5; branch_taken = 1'b1;
      #1; checks++;
      if (outs() !== 7'b011_01_00) begin
         errors++; $display("FAIL bne_resolve: got %b expected %b", outs(), 7'b011_01_00);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_load_ex();
      @(negedge clk);
      id_opcode = 6'h07; id_rs = 5'd8;
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;
      #1; checks++;
      if (outs() !== 7'b100_00_00) begin
         errors++; $display("FAIL bgtz_stall0: got %b expected %b", outs(), 7'b100_00_00);
      end
      @(negedge clk);
      ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
      mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd8;
      #1; checks++;
      if (outs() !== 7'b100_00_00) begin
         errors++; $display("FAIL bgtz_stall1: got %b expected %b", outs(), 7'b100_00_00);
      end
      @(negedge clk);
      mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
      wb_regwrite = 1'b1; wb_rd = 5'd8;
      #1; checks++;
      if (outs() !== 7'b000_10_00) begin
         errors++; $display("FAIL bgtz_resolve: got %b expected %b", outs(), 7'b000_10_00);
      end
      @(negedge clk);
      clear_inputs();
      id_opcode = 6'h23; id_rs = 5'd8;
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;
      #1; checks++;
      if (outs() !== 7'd0) begin
         errors++; $display("FAIL nonbranch_idle: got %b expected %b", outs(), 7'd0);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_r0_and_rt();
      @(negedge clk);
      id_opcode = 6'h06; id_rs = 5'd0; branch_taken = 1'b1;
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0;
      mem_regwrite = 1'b1; mem_rd = 5'd0; wb_regwrite = 1'b1; wb_rd = 5'd0;
      #1; checks++;
      if (outs() !== 7'b011_00_00) begin
         errors++; $display("FAIL blez_r0: got %b expected %b", outs(), 7'b011_00_00);
      end
      @(negedge clk);
      clear_inputs();
      // beq: rs forwarded from WB, rt from MEM ALU; an ALU result in MEM is not a hazard
      id_opcode = 6'h04; id_rs = 5'd1; id_rt = 5'd9;
      mem_regwrite = 1'b1; mem_rd = 5'd9; wb_regwrite = 1'b1; wb_rd = 5'd1;
      #1; checks++;
      if (outs() !== 7'b000_10_01) begin
         errors++; $display("FAIL beq_fwd_both: got %b expected %b", outs(), 7'b000_10_01);
      end
      @(negedge clk);
      clear_inputs();
      // bgez ignores rt: an EX producer of rt is no hazard and rt is not forwarded
      id_opcode = 6'h01; id_rs = 5'd2; id_rt = 5'd9;
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9;
      wb_regwrite = 1'b1; wb_rd = 5'd9; branch_taken = 1'b1;
      #1; checks++;
      if (outs() !== 7'b011_00_00) begin
         errors++; $display("FAIL bgez_rt_ignored: got %b expected %b", outs(), 7'b011_00_00);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk);
      id_opcode = 6'h07; id_rs = 5'd8;
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;
      @(negedge clk);
      ex_regwrite = 1'b0; ex_memread = 1'b0;
      #1; checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL stall_state_held: got %b expected 1", stall);
      end
      #1 reset = 1'b1;
      #1; checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL async_reset_stall: got %b expected 0", stall);
      end
      @(negedge clk);
      reset = 1'b0;
      clear_inputs();
      // Back in IDLE an EX ALU hazard must stall (RESOLVE would not).
      id_opcode = 6'h05; id_rs = 5'd5; ex_regwrite = 1'b1; ex_rd = 5'd5;
      #1; checks++;
      if (outs() !== 7'b100_00_00) begin
         errors++; $display("FAIL idle_after_reset: got %b expected %b", outs(), 7'b100_00_00);
      end
      checks++;
      if (branch_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++; $display("FAIL counts_after_reset: got %0d/%0d expected 0/0", branch_count, taken_count);
      end
      pulse_reset();
   endtask

   task automatic test_stats();
      logic [31:0] eb, et;
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         id_opcode = 6'h04; id_rs = 5'd3; id_rt = 5'd4;
         branch_taken = (i != 1);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      eb = STATS ? 32'd3 : 32'd0;
      et = STATS ? 32'd2 : 32'd0;
      checks++;
      if (branch_count !== eb) begin
         errors++; $display("FAIL branch_count: got %0d expected %0d", branch_count, eb);
      end
      checks++;
      if (taken_count !== et) begin
         errors++; $display("FAIL taken_count: got %0d expected %0d", taken_count, et);
      end
   endtask

   // Model: countdown of cycles until the branch resolves; 0 means nothing pending.
   task automatic test_random();
      logic [5:0] ops [9];
      int cd, ncd, nd;
      logic ib, ur, st, res, exm, memm;
      logic [1:0] ea, eb_sel;
      logic [6:0] exp_o;
      logic [31:0] mb, mt;
      ops = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h00, 6'h23, 6'h2b, 6'h08};
      pulse_reset();
      cd = 0; mb = 0; mt = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         id_opcode    = ops[$urandom_range(0, 8)];
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         ex_regwrite  = 1'($urandom_range(0, 1));
         ex_memread   = 1'($urandom_range(0, 1));
         ex_rd        = 5'($urandom_range(0, 3));
         mem_regwrite = 1'($urandom_range(0, 1));
         mem_memread  = 1'($urandom_range(0, 1));
         mem_rd       = 5'($urandom_range(0, 3));
         wb_regwrite  = 1'($urandom_range(0, 1));
         wb_rd        = 5'($urandom_range(0, 3));
         branch_taken = 1'($urandom_range(0, 1));
         #1;
         ib = (id_opcode == 6'h01) || (id_opcode == 6'h04) || (id_opcode == 6'h05) ||
              (id_opcode == 6'h06) || (id_opcode == 6'h07);
         ur = (id_opcode == 6'h04) || (id_opcode == 6'h05);
         exm  = ex_regwrite && ex_rd != 0 && (ex_rd == id_rs || (ur && ex_rd == id_rt));
         memm = mem_regwrite && mem_rd != 0 && (mem_rd == id_rs || (ur && mem_rd == id_rt));
         nd = 0;
         if (memm && mem_memread) nd = 1;
         if (exm) nd = ex_memread ? 2 : 1;
         st = 0; res = 0; ncd = 0;
         if (cd == 0) begin
            if (ib && nd == 0) res = 1;
            else if (ib) begin st = 1; ncd = nd; end
         end else if (cd == 1) begin
            res = 1;
         end else begin
            st = 1; ncd = cd - 1;
         end
         ea = 0; eb_sel = 0;
         if (ib && id_rs != 0) begin
            if (mem_regwrite && !mem_memread && mem_rd == id_rs) ea = 1;
            else if (wb_regwrite && wb_rd == id_rs)             ea = 2;
         end
         if (ib && ur && id_rt != 0) begin
            if (mem_regwrite && !mem_memread && mem_rd == id_rt) eb_sel = 1;
            else if (wb_regwrite && wb_rd == id_rt)              eb_sel = 2;
         end
         exp_o = {st, res && branch_taken, res && branch_taken, ea, eb_sel};
         checks++;
         if (outs() !== exp_o) begin
            errors++; $display("FAIL rand_outs[%0d]: got %b expected %b", n, outs(), exp_o);
         end
         checks++;
         if (branch_count !== (STATS ? mb : 32'd0) || taken_count !== (STATS ? mt : 32'd0)) begin
            errors++;
            $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", n,
                     branch_count, taken_count, STATS ? mb : 32'd0, STATS ? mt : 32'd0);
         end
         if (res) begin
            mb = mb + 1;
            if (branch_taken) mt = mt + 1;
         end
         cd = ncd;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_no_hazard();
      test_ex_alu();
      test_load_ex();
      test_r0_and_rt();
      test_reset_mid_stall();
      test_stats();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
